// File: rtl/uart_pkg.sv
// Shared UART definitions: the FSM state encoding and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Number of clk cycles per serial bit (integer division, truncating).
  function automatic int clksPerBit(input int clkFreq, input int baud);
    return clkFreq / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver with a two-flop input synchronizer and mid-bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] rxout_o,
  output logic       rxdone_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rxout_q, rxout_d;
  logic          rxdone_q, rxdone_d;
  logic          sync1_q, sync2_q, rxPrev_q;

  // Synchronize the asynchronous line and keep its previous value for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= rx_i;
      sync2_q  <= sync1_q;
      rxPrev_q <= sync2_q;
    end
  end

  // Receiver state, counters, assembled byte and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      rxout_q  <= '0;
      rxdone_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      rxout_q  <= rxout_d;
      rxdone_q <= rxdone_d;
    end
  end

  // Next-state logic; a bad stop bit silently drops the byte.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    rxout_d  = rxout_q;
    rxdone_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        if (rxPrev_q && !sync2_q) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          shift_d  = {sync2_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (sync2_q) begin
            rxout_d  = shift_q;
            rxdone_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rxout_o  = rxout_q;
  assign rxdone_o = rxdone_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; sends frames back-to-back while start_i is held.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] txin_i,
  output logic       tx_o,
  output logic       txdone_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;

  // State, baud counter, bit index and shift register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
    end
  end

  // Next-state logic; tx and txdone are decoded from the registered state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_o     = 1'b1;
    txdone_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        bitIdx_d = '0;
        if (start_i) begin
          state_d = START;
          shift_d = txin_i;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        tx_o = shift_q[0];
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          shift_d  = shift_q >> 1;
          bitIdx_d = bitIdx_q + 1'b1;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          txdone_o = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/top.sv
// Full-duplex UART: independent transmitter and receiver sharing one clock.
module top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] txin,
  output logic       tx,
  input  logic       rx,
  output logic [7:0] rxout,
  output logic       rxdone,
  output logic       txdone
);

  localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD);

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTx (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .txin_i  (txin),
    .tx_o    (tx),
    .txdone_o(txdone)
  );

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uRx (
    .clk_i   (clk),
    .rst_i   (rst),
    .rx_i    (rx),
    .rxout_o (rxout),
    .rxdone_o(rxdone)
  );

endmodule

// File: tb/tb_top.sv
// Loopback bench for top with 16 clocks per bit and a receive scoreboard.
module tb_top;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] txin;
  logic       tx;
  logic       rx;
  logic [7:0] rxout;
  logic       rxdone;
  logic       txdone;
  logic       useLoop;
  logic       rxManual;

  int errors = 0;
  int checks = 0;
  int rxDoneCnt = 0;
  int txDoneCnt = 0;
  logic rxSinceTx = 1'b0;
  logic prevRxdone = 1'b0;
  logic prevTxdone = 1'b0;
  logic [7:0] expQ[$];
  logic [7:0] expByte;

  typedef struct {
    logic [7:0] data;
    logic [7:0] expRx;
  } vec_t;
  vec_t vecs[10];

  assign rx = useLoop ? tx : rxManual;

  top #(.CLK_FREQ(1600000), .BAUD(100000)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .txin  (txin),
    .tx    (tx),
    .rx    (rx),
    .rxout (rxout),
    .rxdone(rxdone),
    .txdone(txdone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    @(negedge clk);
    txin  = d;
    start = 1'b1;
    expQ.push_back(d);
    @(posedge clk);
  endtask

  task automatic waitTxdone(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txdone !== 1'b1 && n < limit);
    if (txdone !== 1'b1) checkOutput("txdone_timeout", 32'(n), 32'(limit + 1));
  endtask

  task automatic sendRxFrame(input logic [7:0] d, input logic stopBit);
    logic [9:0] bits;
    bits = {stopBit, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rxManual = bits[k];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rxManual = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  // Scoreboard: pop the expected byte on every rxdone and track pulse ordering.
  always @(negedge clk) begin
    if (rst) begin
      rxSinceTx = 1'b0;
    end else begin
      if (rxdone) begin
        rxDoneCnt++;
        rxSinceTx = 1'b1;
        checkOutput("rxdone_width", {31'b0, prevRxdone}, 32'd0);
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rx_unexpected: got rxdone with rxout %0h, required none", rxout);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("rxout", {24'b0, rxout}, {24'b0, expByte});
        end
      end
      if (txdone) begin
        txDoneCnt++;
        checkOutput("txdone_width", {31'b0, prevTxdone}, 32'd0);
        checkOutput("rxdone_before_txdone", {31'b0, rxSinceTx}, 32'd1);
        rxSinceTx = 1'b0;
      end
    end
    prevRxdone = rxdone;
    prevTxdone = txdone;
  end

  initial begin
    int rxBase;
    int txBase;
    logic [9:0] bits;
    logic stayedHigh;

    rst      = 1'b1;
    start    = 1'b0;
    txin     = 8'h00;
    useLoop  = 1'b1;
    rxManual = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vecs[i].data  = 8'($urandom_range(10, 200));
      vecs[i].expRx = vecs[i].data;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tx", {31'b0, tx}, 32'd1);
    checkOutput("reset_rxout", {24'b0, rxout}, 32'h00);
    checkOutput("reset_rxdone", {31'b0, rxdone}, 32'd0);
    checkOutput("reset_txdone", {31'b0, txdone}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single A5 frame: bit waveform, drop start during DATA, line stays idle.
    $display("[TB] frame A5 waveform");
    rxBase = rxDoneCnt;
    txBase = txDoneCnt;
    bits = {1'b1, 8'hA5, 1'b0};
    applyStimulus(8'hA5);
    #1;
    for (int k = 0; k < 10; k++) begin
      repeat (8) @(posedge clk);
      #1;
      checkOutput($sformatf("tx_bit%0d", k), {31'b0, tx}, {31'b0, bits[k]});
      if (k == 3) start = 1'b0;
      repeat (8) @(posedge clk);
    end
    #1;
    checkOutput("a5_rxdone_count", 32'(rxDoneCnt - rxBase), 32'd1);
    checkOutput("a5_txdone_count", 32'(txDoneCnt - txBase), 32'd1);
    stayedHigh = 1'b1;
    for (int c = 0; c < 3 * CPB; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) stayedHigh = 1'b0;
    end
    checkOutput("tx_idle_after_stop", {31'b0, stayedHigh}, 32'd1);
    checkOutput("no_extra_frame", 32'(txDoneCnt - txBase), 32'd1);

    // Back-to-back frames from the vector table.
    $display("[TB] back-to-back frames");
    rxBase = rxDoneCnt;
    txBase = txDoneCnt;
    @(negedge clk);
    txin  = vecs[0].data;
    start = 1'b1;
    expQ.push_back(vecs[0].expRx);
    for (int i = 0; i < 10; i++) begin
      waitTxdone(12 * CPB);
      if (i < 9) begin
        txin = vecs[i + 1].data;
        expQ.push_back(vecs[i + 1].expRx);
      end else begin
        start = 1'b0;
      end
    end
    repeat (40) @(negedge clk);
    checkOutput("b2b_rxdone_count", 32'(rxDoneCnt - rxBase), 32'd10);
    checkOutput("b2b_txdone_count", 32'(txDoneCnt - txBase), 32'd10);
    checkOutput("b2b_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("b2b_last_rxout", {24'b0, rxout}, {24'b0, vecs[9].expRx});

    // Short low glitch on an idle line.
    $display("[TB] rx glitch");
    rxManual = 1'b1;
    useLoop  = 1'b0;
    rxBase   = rxDoneCnt;
    repeat (4) @(negedge clk);
    rxManual = 1'b0;
    repeat (4) @(negedge clk);
    rxManual = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch_no_rxdone", 32'(rxDoneCnt - rxBase), 32'd0);
    checkOutput("glitch_rxout", {24'b0, rxout}, {24'b0, vecs[9].expRx});

    // Framing error, then a good frame on the same line.
    $display("[TB] framing error");
    sendRxFrame(8'h3C, 1'b0);
    checkOutput("frame_err_no_rxdone", 32'(rxDoneCnt - rxBase), 32'd0);
    checkOutput("frame_err_rxout", {24'b0, rxout}, {24'b0, vecs[9].expRx});
    expQ.push_back(8'h5A);
    sendRxFrame(8'h5A, 1'b1);
    checkOutput("good_after_err_count", 32'(rxDoneCnt - rxBase), 32'd1);
    checkOutput("good_after_err_rxout", {24'b0, rxout}, 32'h5A);

    // Reset in the middle of DATA, then a fresh frame after release.
    $display("[TB] reset mid-frame");
    useLoop   = 1'b1;
    rxSinceTx = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(8'h77);
    repeat (3 * CPB) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_tx", {31'b0, tx}, 32'd1);
    checkOutput("rst_mid_rxout", {24'b0, rxout}, 32'h00);
    checkOutput("rst_mid_rxdone", {31'b0, rxdone}, 32'd0);
    checkOutput("rst_mid_txdone", {31'b0, txdone}, 32'd0);
    expQ.delete();
    rxBase = rxDoneCnt;
    txBase = txDoneCnt;
    txin = 8'h3B;
    expQ.push_back(8'h3B);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waitTxdone(12 * CPB);
    start = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("post_rst_rxdone_count", 32'(rxDoneCnt - rxBase), 32'd1);
    checkOutput("post_rst_txdone_count", 32'(txDoneCnt - txBase), 32'd1);
    checkOutput("post_rst_rxout", {24'b0, rxout}, 32'h3B);
    checkOutput("post_rst_queue_empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
